pit_multi: RTL and testbench

- Parametrised 8254-style programmable interval timer with up to three 16-bit channels on the 16-bit data_m bus at I/O 40h-43h.
- Adds mode 4, odd-count square waves, per-channel gates, status latching and the read-back command.
- Channel 0 drives the system interrupt; channel 2 drives the speaker.
- pit_clk is synchronised and edge-detected internally; all logic runs on clk.

---
 rtl/pit_multi.sv | 239 +++++++++++++++++++++++
 tb/tb_pit_multi.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_multi.sv
// pit_multi: 8254-style interval timer with up to three 16-bit channels.
// pit_clk is synchronised into clk; all counting happens on its rising edge.
module pit_multi #(
  parameter int NUM_CHANNELS = 3,
  parameter int SYNC_STAGES  = 2,
  parameter bit HAS_READBACK = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pit_clk,
  input  logic                    cs,
  input  logic [1:1]              data_m_addr,
  input  logic [15:0]             data_m_data_in,
  output logic [15:0]             data_m_data_out,
  input  logic [1:0]              data_m_bytesel,
  input  logic                    data_m_wr_en,
  input  logic                    data_m_access,
  output logic                    data_m_ack,
  input  logic [NUM_CHANNELS-1:0] gate,
  output logic [NUM_CHANNELS-1:0] out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic pclk_q, tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      pclk_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pit_clk};
      pclk_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~pclk_q;

  logic hit, rd, wr, ctl_wr;
  logic [2:0] sel;
  logic [7:0] cw;
  logic [7:0] rd_byte [3];
  logic [15:0] rdata;

  assign hit = cs & data_m_access;
  assign rd = hit & ~data_m_wr_en;
  assign wr = hit & data_m_wr_en;
  assign sel[0] = ~data_m_addr[1] & data_m_bytesel[0];
  assign sel[1] = ~data_m_addr[1] & data_m_bytesel[1];
  assign sel[2] = data_m_addr[1] & data_m_bytesel[0];
  assign ctl_wr = wr & data_m_addr[1] & data_m_bytesel[1];
  assign cw = data_m_data_in[15:8];

  always_comb begin
    rdata = '0;
    if (!data_m_addr[1]) begin
      if (data_m_bytesel[0]) rdata[7:0] = rd_byte[0];
      if (data_m_bytesel[1]) rdata[15:8] = rd_byte[1];
    end else if (data_m_bytesel[0]) begin
      rdata[7:0] = rd_byte[2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_m_ack <= 1'b0;
      data_m_data_out <= '0;
    end else begin
      data_m_ack <= hit;
      data_m_data_out <= rd ? rdata : 16'h0000;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    if (i < NUM_CHANNELS) begin : g_on
      logic [2:0] mode;
      logic [1:0] rw;
      logic bcd, nul, run, ld, wtog, rtog, trig, gq, o;
      logic [15:0] cr, nv, cnt, ol, rsrc, ldv;
      logic ol_v, st_v;
      logic [7:0] st, wb;
      logic m0, m2, m3, m4, cwr, crd, csel, rb, rhi;

      assign m0 = ~mode[2] & ~mode[1];
      assign m4 = mode[2] & ~mode[1];
      assign m2 = mode[1] & ~mode[0];
      assign m3 = mode[1] & mode[0];
      assign wb = (i == 1) ? data_m_data_in[15:8] : data_m_data_in[7:0];
      assign cwr = wr & sel[i];
      assign crd = rd & sel[i];
      assign csel = ctl_wr & (cw[7:6] == 2'(i));
      assign rb = ctl_wr & HAS_READBACK & (cw[7:6] == 2'b11) & cw[1+i];
      // odd mode-3 counts start with the longer (N+1) high half
      assign ldv = m3 ? cr + {15'd0, cr[0]} : cr;
      assign rsrc = ol_v ? ol : cnt;
      assign rhi = (rw == 2'b10) | ((rw == 2'b11) & rtog);
      assign rd_byte[i] = st_v ? st : (rhi ? rsrc[15:8] : rsrc[7:0]);
      assign out[i] = o;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mode <= 3'd0;
          rw <= 2'b11;
          bcd <= 1'b0;
          nul <= 1'b0;
          run <= 1'b0;
          ld <= 1'b0;
          wtog <= 1'b0;
          rtog <= 1'b0;
          trig <= 1'b0;
          gq <= 1'b0;
          o <= 1'b0;
          cr <= '0;
          nv <= '0;
          cnt <= '0;
          ol <= '0;
          ol_v <= 1'b0;
          st <= '0;
          st_v <= 1'b0;
        end else begin
          gq <= gate[i];
          if (tick) begin
            trig <= 1'b0;
            if (ld) begin
              cnt <= ldv;
              nv <= cr;
              run <= 1'b1;
              nul <= 1'b0;
              ld <= 1'b0;
              o <= ~m0;
            end else if (run) begin
              if ((m2 | m3) && trig) begin
                cnt <= m3 ? nv + {15'd0, nv[0]} : nv;
                o <= 1'b1;
              end else if (gate[i]) begin
                unique case (1'b1)
                  m0: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) o <= 1'b1;
                  end
                  m4: begin
                    cnt <= cnt - 16'd1;
                    o <= (cnt != 16'd1);
                  end
                  m2: begin
                    if (cnt == 16'd1) begin
                      cnt <= nv;
                      o <= 1'b0;
                    end else begin
                      cnt <= cnt - 16'd1;
                      o <= 1'b1;
                    end
                  end
                  m3: begin
                    if (cnt == 16'd2) begin
                      o <= ~o;
                      cnt <= o ? nv - {15'd0, nv[0]} : nv + {15'd0, nv[0]};
                    end else begin
                      cnt <= cnt - 16'd2;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
          if ((m2 | m3) && !gate[i]) o <= 1'b1;
          if (gate[i] && !gq) trig <= 1'b1;
          if (crd) begin
            if (st_v) begin
              st_v <= 1'b0;
            end else begin
              if (rw == 2'b11) rtog <= ~rtog;
              if (ol_v && (rw != 2'b11 || rtog)) ol_v <= 1'b0;
            end
          end
          if (cwr) begin
            nul <= 1'b1;
            if (m0) o <= 1'b0;
            case (rw)
              2'b01: begin
                cr <= {8'h00, wb};
                ld <= 1'b1;
              end
              2'b10: begin
                cr <= {wb, 8'h00};
                ld <= 1'b1;
              end
              default: begin
                if (!wtog) begin
                  cr[7:0] <= wb;
                  wtog <= 1'b1;
                  if (m0) run <= 1'b0;
                end else begin
                  cr[15:8] <= wb;
                  wtog <= 1'b0;
                  ld <= 1'b1;
                end
              end
            endcase
          end
          if (csel) begin
            if (cw[5:4] == 2'b00) begin
              if (!ol_v) begin
                ol <= cnt;
                ol_v <= 1'b1;
              end
            end else begin
              rw <= cw[5:4];
              mode <= cw[3:1];
              bcd <= cw[0];
              wtog <= 1'b0;
              rtog <= 1'b0;
              nul <= 1'b1;
              run <= 1'b0;
              ld <= 1'b0;
              ol_v <= 1'b0;
              st_v <= 1'b0;
              trig <= 1'b0;
              o <= (cw[3:1] != 3'd0);
            end
          end
          if (rb) begin
            if (!cw[5] && !ol_v) begin
              ol <= cnt;
              ol_v <= 1'b1;
            end
            if (!cw[4] && !st_v) begin
              st <= {o, nul, rw, mode, bcd};
              st_v <= 1'b1;
            end
          end
        end
      end
    end else begin : g_off
      assign rd_byte[i] = 8'h00;
    end
  end

endmodule

// File: tb/tb_pit_multi.sv
// tb_pit_multi: directed sequence with randomized counts, checked against
// closed-form expectations for each timer mode.
module tb_pit_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pit_clk = 1'b0;
  logic cs = 1'b0, cs2 = 1'b0;
  logic [1:1] addr = '0;
  logic [15:0] din = '0, dout, dout2;
  logic [1:0] be = '0;
  logic wen = 1'b0, acc = 1'b0, ack, ack2;
  logic [2:0] gate = 3'b111;
  logic [2:0] pout;
  logic [1:0] pout2;
  int total = 0, bad = 0, tcount = 0;
  int mmode[3], mn[3], mload[3];
  bit mvalid[3];

  always #5 clk = ~clk;

  pit_multi u_dut (
    .clk(clk), .reset_n(reset_n), .pit_clk(pit_clk), .cs(cs),
    .data_m_addr(addr), .data_m_data_in(din), .data_m_data_out(dout),
    .data_m_bytesel(be), .data_m_wr_en(wen), .data_m_access(acc),
    .data_m_ack(ack), .gate(gate), .out(pout)
  );

  pit_multi #(.NUM_CHANNELS(2), .HAS_READBACK(1'b0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .pit_clk(pit_clk), .cs(cs2),
    .data_m_addr(addr), .data_m_data_in(din), .data_m_data_out(dout2),
    .data_m_bytesel(be), .data_m_wr_en(wen), .data_m_access(acc),
    .data_m_ack(ack2), .gate(2'b11), .out(pout2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_out(int c);
    int k = tcount - mload[c];
    int n = (mn[c] == 0) ? 65536 : mn[c];
    case (mmode[c])
      0: return k >= n;
      2: return !(k > 0 && k % n == 0);
      3: return (k % n) < (n + 1) / 2;
      4: return k != n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_cnt(int c);
    int k = tcount - mload[c];
    int n = (mn[c] == 0) ? 65536 : mn[c];
    if (mmode[c] == 2) return (n - k % n) & 'hFFFF;
    return (n - k) & 'hFFFF;
  endfunction

  task automatic bus(input bit w, input bit a, input logic [1:0] b,
                     input logic [15:0] d, input bit d2,
                     output logic [15:0] q);
    cs = ~d2; cs2 = d2; acc = 1'b1; wen = w;
    addr[1] = a; be = b; din = d;
    @(negedge clk);
    cs = 1'b0; cs2 = 1'b0; acc = 1'b0; wen = 1'b0; be = '0; din = '0;
    q = d2 ? dout2 : dout;
    chk("ack", d2 ? ack2 : ack, 1);
    if (w) chk("wr_data0", q, 0);
    @(negedge clk);
    chk("ack_drop", d2 ? ack2 : ack, 0);
  endtask

  task automatic ctrl(input logic [7:0] b, input bit d2 = 1'b0);
    logic [15:0] q;
    bus(1'b1, 1'b1, 2'b10, {b, 8'h00}, d2, q);
  endtask

  task automatic wcnt(input int c, input logic [7:0] b, input bit d2 = 1'b0);
    logic [15:0] q;
    case (c)
      0: bus(1'b1, 1'b0, 2'b01, {8'h00, b}, d2, q);
      1: bus(1'b1, 1'b0, 2'b10, {b, 8'h00}, d2, q);
      default: bus(1'b1, 1'b1, 2'b01, {8'h00, b}, d2, q);
    endcase
  endtask

  task automatic rcnt(input int c, output logic [7:0] v, input bit d2 = 1'b0);
    logic [15:0] q;
    case (c)
      0: bus(1'b0, 1'b0, 2'b01, 16'h0, d2, q);
      1: bus(1'b0, 1'b0, 2'b10, 16'h0, d2, q);
      default: bus(1'b0, 1'b1, 2'b01, 16'h0, d2, q);
    endcase
    v = (c == 1) ? q[15:8] : q[7:0];
  endtask

  task automatic rword(input int c, output logic [15:0] v, input bit d2 = 1'b0);
    logic [7:0] lo, hi;
    rcnt(c, lo, d2);
    rcnt(c, hi, d2);
    v = {hi, lo};
  endtask

  task automatic wword(input int c, input int n, input bit d2 = 1'b0);
    logic [15:0] w;
    w = 16'(n);
    wcnt(c, w[7:0], d2);
    wcnt(c, w[15:8], d2);
  endtask

  task automatic do_tick();
    pit_clk = 1'b1;
    repeat (4) @(negedge clk);
    pit_clk = 1'b0;
    repeat (4) @(negedge clk);
    tcount++;
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++)
      if (mvalid[c]) chk($sformatf("out%0d", c), pout[c], exp_out(c));
  endtask

  task automatic run(input int t);
    for (int j = 0; j < t; j++) begin
      do_tick();
      check_all();
    end
  endtask

  task automatic setup(input int c, input logic [7:0] cwd, input int md,
                       input int n);
    mvalid[c] = 1'b0;
    ctrl(cwd);
    wword(c, n);
    do_tick();
    mmode[c] = md; mn[c] = n; mload[c] = tcount; mvalid[c] = 1'b1;
    check_all();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [15:0] v, lv;
    logic [7:0] s, b8, st_exp;
    int n, n2, r, pc;
    repeat (3) @(negedge clk);
    chk("rst_out", pout, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dout", dout, 0);
    reset_n = 1'b1;
    @(negedge clk);
    rword(0, v);
    chk("rst_cnt0", v, 0);

    setup(0, 8'h34, 2, 4);
    run(12);
    n = $urandom_range(2, 12);
    setup(0, 8'h34, 2, n);
    run(2 * n + 1);

    setup(2, 8'hB6, 3, 5);
    run(10);
    n = $urandom_range(3, 9);
    setup(2, 8'hB6, 3, n);
    run(2 * n);
    for (int i = 0; i < 20 && exp_out(2) != 1'b0; i++) begin
      do_tick();
      check_all();
    end
    gate[2] = 1'b0;
    mvalid[2] = 1'b0;
    @(negedge clk);
    chk("gate_low_out", pout[2], 1);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check_all();
      chk("gate_hold", pout[2], 1);
    end
    gate[2] = 1'b1;
    @(negedge clk);
    do_tick();
    mload[2] = tcount;
    mvalid[2] = 1'b1;
    check_all();
    run(2 * mn[2]);

    mvalid[1] = 1'b0;
    ctrl(8'h70);
    chk("m0_ctl_out", pout[1], 0);
    n = $urandom_range(2, 8);
    wword(1, n);
    chk("m0_wr_out", pout[1], 0);
    do_tick();
    mmode[1] = 0; mn[1] = n; mload[1] = tcount; mvalid[1] = 1'b1;
    check_all();
    run(n + 2);
    pc = exp_cnt(1);
    mvalid[1] = 1'b0;
    n2 = $urandom_range(2, 6);
    wcnt(1, 8'(n2));
    chk("m0_lo_out", pout[1], 0);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("m0_pause_out", pout[1], 0);
    end
    ctrl(8'h40);
    rword(1, v);
    chk("m0_pause_cnt", v, pc);
    wcnt(1, 8'h00);
    do_tick();
    mn[1] = n2; mload[1] = tcount; mvalid[1] = 1'b1;
    check_all();
    run(n2 + 1);

    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 'h1234 : $urandom_range(1000, 60000);
      setup(0, 8'h30, 0, n);
      r = $urandom_range(1, 20);
      run(r);
      lv = 16'(exp_cnt(0));
      ctrl(8'h00);
      run(5);
      ctrl(8'h00);
      run(5);
      rcnt(0, b8);
      chk("latch_lo", b8, lv[7:0]);
      rcnt(0, b8);
      chk("latch_hi", b8, lv[15:8]);
      rword(0, v);
      chk("latch_live", v, exp_cnt(0));
    end

    n = $urandom_range(3, 10);
    mvalid[0] = 1'b0;
    ctrl(8'h34);
    wword(0, n);
    ctrl(8'hE2);
    rcnt(0, s);
    chk("rb_st_null", s, {1'b1, 1'b1, 2'b11, 3'b010, 1'b0});
    do_tick();
    mmode[0] = 2; mn[0] = n; mload[0] = tcount; mvalid[0] = 1'b1;
    check_all();
    r = $urandom_range(1, 15);
    run(r);
    ctrl(8'hC2);
    st_exp = {exp_out(0), 1'b0, 2'b11, 3'b010, 1'b0};
    lv = 16'(exp_cnt(0));
    run(2);
    rcnt(0, s);
    chk("rb_status", s, st_exp);
    rword(0, v);
    chk("rb_count", v, lv);
    rword(0, v);
    chk("rb_live", v, exp_cnt(0));
    ctrl(8'hD2);
    lv = 16'(exp_cnt(0));
    run(1);
    rword(0, v);
    chk("rb_cnt_only", v, lv);

    n = $urandom_range(2, 6);
    mvalid[1] = 1'b0;
    ctrl(8'h78);
    chk("m4_ctl_out", pout[1], 1);
    wword(1, n);
    do_tick();
    mmode[1] = 4; mn[1] = n; mload[1] = tcount; mvalid[1] = 1'b1;
    check_all();
    run(n + 2);

    ctrl(8'hB0, 1'b1);
    wword(2, 'h55, 1'b1);
    rcnt(2, b8, 1'b1);
    chk("nc_rd", b8, 0);
    ctrl(8'h34, 1'b1);
    wword(0, 5, 1'b1);
    do_tick();
    check_all();
    ctrl(8'hC2, 1'b1);
    rword(0, v, 1'b1);
    chk("no_rb_live", v, 5);
    chk("dut2_out", pout2, 2'b01);

    cs = 1'b1; acc = 1'b1; addr[1] = 1'b0; be = 2'b01; wen = 1'b0;
    @(negedge clk);
    cs = 1'b0; acc = 1'b0; be = '0;
    chk("pre_rst_ack", ack, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", pout, 0);
    chk("arst_ack", ack, 0);
    chk("arst_dout", dout, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) mvalid[c] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("arst_idle_out", pout, 0);
    end
    rword(0, v);
    chk("arst_cnt", v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
